// File: rtl/tri_cfg_pkg.sv
// ============================================================================
// Module      : tri_cfg_pkg
// Description : Shared widths, FSM state encodings and vertex register indices
//               for the triangle configuration controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tri_cfg_pkg;

    localparam int COORD_W = 12;
    localparam int AREA_W  = 2*COORD_W + 2;
    localparam int ACC_W   = AREA_W + 1;
    localparam int DIFF_W  = COORD_W + 1;
    localparam int PROD_W  = 2*COORD_W + 1;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_CALC0   = 3'd1;
    localparam state_t ST_CALC1   = 3'd2;
    localparam state_t ST_CALC2   = 3'd3;
    localparam state_t ST_ABS     = 3'd4;
    localparam state_t ST_WAIT_FS = 3'd5;
    localparam state_t ST_COMMIT  = 3'd6;

    localparam logic [2:0] IDX_X1 = 3'd0;
    localparam logic [2:0] IDX_Y1 = 3'd1;
    localparam logic [2:0] IDX_X2 = 3'd2;
    localparam logic [2:0] IDX_Y2 = 3'd3;
    localparam logic [2:0] IDX_X3 = 3'd4;
    localparam logic [2:0] IDX_Y3 = 3'd5;

endpackage

`default_nettype wire

// File: rtl/tri_area_mac.sv
// ============================================================================
// Module      : tri_area_mac
// Description : Shared multiply-accumulate for the doubled triangle area:
//               acc += x * (ya - yb), x unsigned, result signed.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tri_area_mac
    import tri_cfg_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [COORD_W-1:0]       x,
    input  logic [COORD_W-1:0]       ya,
    input  logic [COORD_W-1:0]       yb,
    input  logic                     clr,
    input  logic                     en,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [DIFF_W-1:0] diff;
    logic signed [PROD_W-1:0] x_ext;
    logic signed [PROD_W-1:0] diff_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  acc_q;

    // Both y values fit in 12 unsigned bits, so a 13-bit signed difference never wraps.
    assign diff     = $signed({1'b0, ya}) - $signed({1'b0, yb});
    assign x_ext    = {{(PROD_W-COORD_W){1'b0}}, x};
    assign diff_ext = {{(PROD_W-DIFF_W){diff[DIFF_W-1]}}, diff};
    assign prod     = x_ext * diff_ext;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

`default_nettype wire

// File: rtl/tri_config_ctrl.sv
// ============================================================================
// Module      : tri_config_ctrl
// Description : Shadow/active vertex configuration with frame-synchronous commit
//               and precomputed doubled area. Optional macro TRI_CFG_DROP_DEGEN_EN
//               drops zero-area sets instead of committing them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tri_config_ctrl
    import tri_cfg_pkg::*;
(
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [2:0]          wr_idx,
    input  logic [COORD_W-1:0]  wr_data,
    input  logic                wr_last,
    input  logic                frame_start,
    output logic [COORD_W-1:0]  tri_x1,
    output logic [COORD_W-1:0]  tri_y1,
    output logic [COORD_W-1:0]  tri_x2,
    output logic [COORD_W-1:0]  tri_y2,
    output logic [COORD_W-1:0]  tri_x3,
    output logic [COORD_W-1:0]  tri_y3,
    output logic [AREA_W-1:0]   tri_area2,
    output logic                tri_neg,
    output logic                tri_degenerate,
    output logic                busy,
    output logic                commit_pulse,
    output logic                cfg_reject
);

    state_t                    state_d, state_q;
    logic [5:0][COORD_W-1:0]   shadow_d, shadow_q;
    logic [5:0][COORD_W-1:0]   active_d, active_q;
    logic [AREA_W-1:0]         area_d, area_q;
    logic                      neg_d, neg_q;
    logic                      degen_d, degen_q;
    logic [AREA_W-1:0]         mag_d, mag_q;
    logic                      lneg_d, lneg_q;
    logic                      ldegen_d, ldegen_q;
    logic                      commit_pulse_d, commit_pulse_q;
    logic                      cfg_reject_d;

    logic [COORD_W-1:0]        mac_x, mac_ya, mac_yb;
    logic                      mac_clr, mac_en;
    logic signed [ACC_W-1:0]   acc;
    logic [AREA_W-1:0]         acc_abs;
    logic                      acc_zero;

    assign wr_ready = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);

    assign mac_clr  = (state_q == ST_IDLE);
    assign mac_en   = (state_q == ST_CALC0) || (state_q == ST_CALC1) || (state_q == ST_CALC2);

    // Step k feeds x_k, y_(k+1), y_(k+2) with indices taken mod 3.
    always_comb begin
        mac_x  = shadow_q[IDX_X1];
        mac_ya = shadow_q[IDX_Y2];
        mac_yb = shadow_q[IDX_Y3];
        case (state_q)
            ST_CALC1: begin
                mac_x  = shadow_q[IDX_X2];
                mac_ya = shadow_q[IDX_Y3];
                mac_yb = shadow_q[IDX_Y1];
            end
            ST_CALC2: begin
                mac_x  = shadow_q[IDX_X3];
                mac_ya = shadow_q[IDX_Y1];
                mac_yb = shadow_q[IDX_Y2];
            end
            default: ;
        endcase
    end

    tri_area_mac u_mac (
        .clk   (CLOCK_50),
        .rst_n (RESET_N),
        .x     (mac_x),
        .ya    (mac_ya),
        .yb    (mac_yb),
        .clr   (mac_clr),
        .en    (mac_en),
        .acc   (acc)
    );

    // The accumulator magnitude is always below 2^26, so the low bits carry it fully.
    assign acc_abs  = acc[ACC_W-1] ? (~acc[AREA_W-1:0] + AREA_W'(1)) : acc[AREA_W-1:0];
    assign acc_zero = (acc == '0);

    always_comb begin
        state_d        = state_q;
        shadow_d       = shadow_q;
        active_d       = active_q;
        area_d         = area_q;
        neg_d          = neg_q;
        degen_d        = degen_q;
        mag_d          = mag_q;
        lneg_d         = lneg_q;
        ldegen_d       = ldegen_q;
        commit_pulse_d = 1'b0;
        cfg_reject_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_valid) begin
                    case (wr_idx)
                        IDX_X1:  shadow_d[IDX_X1] = wr_data;
                        IDX_Y1:  shadow_d[IDX_Y1] = wr_data;
                        IDX_X2:  shadow_d[IDX_X2] = wr_data;
                        IDX_Y2:  shadow_d[IDX_Y2] = wr_data;
                        IDX_X3:  shadow_d[IDX_X3] = wr_data;
                        IDX_Y3:  shadow_d[IDX_Y3] = wr_data;
                        default: ;
                    endcase
                    if (wr_last) begin
                        state_d = ST_CALC0;
                    end
                end
            end
            ST_CALC0: state_d = ST_CALC1;
            ST_CALC1: state_d = ST_CALC2;
            ST_CALC2: state_d = ST_ABS;
            ST_ABS: begin
                mag_d    = acc_abs;
                lneg_d   = acc[ACC_W-1];
                ldegen_d = acc_zero;
`ifdef TRI_CFG_DROP_DEGEN_EN
                if (acc_zero) begin
                    state_d      = ST_IDLE;
                    cfg_reject_d = 1'b1;
                end else begin
                    state_d = ST_WAIT_FS;
                end
`else
                state_d = ST_WAIT_FS;
`endif
            end
            ST_WAIT_FS: begin
                if (frame_start) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                active_d       = shadow_q;
                area_d         = mag_q;
                neg_d          = lneg_q;
                degen_d        = ldegen_q;
                commit_pulse_d = 1'b1;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q        <= ST_IDLE;
            shadow_q       <= '0;
            active_q       <= '0;
            area_q         <= '0;
            neg_q          <= 1'b0;
            degen_q        <= 1'b1;
            mag_q          <= '0;
            lneg_q         <= 1'b0;
            ldegen_q       <= 1'b1;
            commit_pulse_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            shadow_q       <= shadow_d;
            active_q       <= active_d;
            area_q         <= area_d;
            neg_q          <= neg_d;
            degen_q        <= degen_d;
            mag_q          <= mag_d;
            lneg_q         <= lneg_d;
            ldegen_q       <= ldegen_d;
            commit_pulse_q <= commit_pulse_d;
        end
    end

`ifdef TRI_CFG_DROP_DEGEN_EN
    logic cfg_reject_q;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            cfg_reject_q <= 1'b0;
        end else begin
            cfg_reject_q <= cfg_reject_d;
        end
    end

    assign cfg_reject = cfg_reject_q;
`else
    logic unused_reject;
    assign unused_reject = cfg_reject_d;
    assign cfg_reject    = 1'b0;
`endif

    assign tri_x1         = active_q[IDX_X1];
    assign tri_y1         = active_q[IDX_Y1];
    assign tri_x2         = active_q[IDX_X2];
    assign tri_y2         = active_q[IDX_Y2];
    assign tri_x3         = active_q[IDX_X3];
    assign tri_y3         = active_q[IDX_Y3];
    assign tri_area2      = area_q;
    assign tri_neg        = neg_q;
    assign tri_degenerate = degen_q;
    assign commit_pulse   = commit_pulse_q;

endmodule

`default_nettype wire

// File: tb/tb_tri_config_ctrl.sv
// ============================================================================
// Module      : tb_tri_config_ctrl
// Description : Scoreboard bench for tri_config_ctrl; expected commits are queued
//               by the stimulus and checked by a monitor on commit_pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tri_config_ctrl;

    logic        CLOCK_50;
    logic        RESET_N;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_idx;
    logic [11:0] wr_data;
    logic        wr_last;
    logic        frame_start;
    logic [11:0] tri_x1, tri_y1, tri_x2, tri_y2, tri_x3, tri_y3;
    logic [25:0] tri_area2;
    logic        tri_neg;
    logic        tri_degenerate;
    logic        busy;
    logic        commit_pulse;
    logic        cfg_reject;

    tri_config_ctrl dut (
        .CLOCK_50       (CLOCK_50),
        .RESET_N        (RESET_N),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_idx         (wr_idx),
        .wr_data        (wr_data),
        .wr_last        (wr_last),
        .frame_start    (frame_start),
        .tri_x1         (tri_x1),
        .tri_y1         (tri_y1),
        .tri_x2         (tri_x2),
        .tri_y2         (tri_y2),
        .tri_x3         (tri_x3),
        .tri_y3         (tri_y3),
        .tri_area2      (tri_area2),
        .tri_neg        (tri_neg),
        .tri_degenerate (tri_degenerate),
        .busy           (busy),
        .commit_pulse   (commit_pulse),
        .cfg_reject     (cfg_reject)
    );

    typedef struct {
        logic [71:0] verts;
        logic [25:0] area;
        logic        neg;
        logic        degen;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_rej = 0;
    int   exp_rej = 0;
    int   cyc = 0;

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Monitor: every commit pulse must match the oldest queued expectation.
    always @(negedge CLOCK_50) begin
        if (RESET_N && commit_pulse) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_commit: commit_pulse=1 at cycle %0d, required no commit", cyc);
            end else begin
                e = sb.pop_front();
                if ({tri_x1, tri_y1, tri_x2, tri_y2, tri_x3, tri_y3} !== e.verts ||
                    tri_area2 !== e.area || tri_neg !== e.neg || tri_degenerate !== e.degen ||
                    cyc != e.cyc || wr_ready !== 1'b1 || busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL commit: got verts=%h area=%0d neg=%b degen=%b cyc=%0d rdy=%b busy=%b, required verts=%h area=%0d neg=%b degen=%b cyc=%0d rdy=1 busy=0",
                             {tri_x1, tri_y1, tri_x2, tri_y2, tri_x3, tri_y3}, tri_area2, tri_neg,
                             tri_degenerate, cyc, wr_ready, busy, e.verts, e.area, e.neg, e.degen, e.cyc);
                end
            end
        end
        if (RESET_N && cfg_reject) n_rej++;
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] req);
        n_cmp++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic write(input logic [2:0] idx, input logic [11:0] data, input logic last);
        wr_valid = 1'b1;
        wr_idx   = idx;
        wr_data  = data;
        wr_last  = last;
        check("wr_ready_idle", 128'(wr_ready), 128'(1));
        tick();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic load(input logic [11:0] x1, y1, x2, y2, x3, y3);
        write(3'd0, x1, 1'b0);
        write(3'd1, y1, 1'b0);
        write(3'd2, x2, 1'b0);
        write(3'd3, y2, 1'b0);
        write(3'd4, x3, 1'b0);
        write(3'd5, y3, 1'b1);
    endtask

    task automatic fs_commit(input logic [71:0] v, input logic [25:0] a, input logic n, input logic d);
        exp_t x;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        x.verts = v; x.area = a; x.neg = n; x.degen = d; x.cyc = cyc + 1;
        sb.push_back(x);
    endtask

    task automatic wait_commit();
        int i;
        i = 0;
        while (sb.size() != 0 && i < 20) begin
            tick();
            i++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL commit_timeout: %0d commits outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    function automatic logic [127:0] out_vec();
        return 128'({tri_x1, tri_y1, tri_x2, tri_y2, tri_x3, tri_y3, tri_area2,
                     tri_neg, tri_degenerate, busy, wr_ready, commit_pulse, cfg_reject});
    endfunction

    // Reset state: all vertices/area zero, degenerate=1, busy=0, wr_ready=1.
    localparam logic [127:0] RST_VEC = 128'({72'd0, 26'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});

    initial begin
        RESET_N = 1'b0; wr_valid = 1'b0; wr_idx = 3'd0; wr_data = 12'd0;
        wr_last = 1'b0; frame_start = 1'b0;
        repeat (3) tick();
        check("reset_values", out_vec(), RST_VEC);
        RESET_N = 1'b1;
        tick();
        check("post_reset_idle", out_vec(), RST_VEC);

        // Triangle A: doubled area -182000, clockwise.
        load(12'd286, 12'd36, 12'd300, 12'd300, 12'd1000, 12'd500);
        check("busy_after_last", 128'({busy, wr_ready}), 128'(2'b10));
        wr_valid = 1'b1; wr_idx = 3'd0; wr_data = 12'd999;
        for (int k = 0; k < 3; k++) begin
            check("wr_ready_busy", 128'(wr_ready), 128'(0));
            tick();
        end
        wr_valid = 1'b0;
        repeat (7) tick();
        check("wait_fs_busy", 128'(busy), 128'(1));
        fs_commit({12'd286, 12'd36, 12'd300, 12'd300, 12'd1000, 12'd500}, 26'd182000, 1'b1, 1'b0);
        wait_commit();
        check("commit_pulse_one_cycle", 128'(commit_pulse), 128'(0));

        // Triangle B with a frame_start landing during CALC: ignored.
        load(12'd10, 12'd20, 12'd100, 12'd20, 12'd10, 12'd200);
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (8) tick();
        check("no_commit_during_calc", 128'(tri_x1), 128'(286));
        fs_commit({12'd10, 12'd20, 12'd100, 12'd20, 12'd10, 12'd200}, 26'd16200, 1'b0, 1'b0);
        wait_commit();

        // Idx 6/7 writes are accepted with no effect; then a max-coordinate triangle.
        write(3'd6, 12'd123, 1'b0);
        write(3'd7, 12'd456, 1'b0);
        load(12'd4095, 12'd0, 12'd0, 12'd4095, 12'd0, 12'd0);
        repeat (6) tick();
        fs_commit({12'd4095, 12'd0, 12'd0, 12'd4095, 12'd0, 12'd0}, 26'd16769025, 1'b0, 1'b0);
        wait_commit();

        // Degenerate (0,0),(10,10),(20,20).
        load(12'd0, 12'd0, 12'd10, 12'd10, 12'd20, 12'd20);
        repeat (6) tick();
`ifdef TRI_CFG_DROP_DEGEN_EN
        exp_rej = 1;
        check("degen_dropped_idle", 128'(busy), 128'(0));
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (4) tick();
        check("degen_outputs_held", out_vec(),
              128'({12'd4095, 12'd0, 12'd0, 12'd4095, 12'd0, 12'd0, 26'd16769025,
                    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}));
`else
        fs_commit({12'd0, 12'd0, 12'd10, 12'd10, 12'd20, 12'd20}, 26'd0, 1'b0, 1'b1);
        wait_commit();
`endif
        check("cfg_reject_count", 128'(n_rej), 128'(exp_rej));

        // Reset asserted in WAIT_FS: no commit afterwards, reset outputs.
        load(12'd50, 12'd60, 12'd70, 12'd80, 12'd90, 12'd200);
        repeat (8) tick();
        check("wait_fs_before_reset", 128'(busy), 128'(1));
        RESET_N = 1'b0;
        tick();
        check("reset_in_wait_fs", out_vec(), RST_VEC);
        tick();
        RESET_N = 1'b1;
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (4) tick();
        check("no_commit_after_reset", out_vec(), RST_VEC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
